// File: rtl/mult_share_ctrl_pkg.sv
// mult_pkg: shared types for the time-shared shift-add multiplier.
//   state_e   sequencer states
//   CNT_W     step-counter width for the default 8-bit datapath
//   cnt_bits  step-counter width for any operand width (never below 1 bit)
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        SHIFT,
        DONE
    } state_e;

    localparam int WIDTH_DEF = 8;
    localparam int CNT_W     = $clog2(WIDTH_DEF);

    function automatic int cnt_bits(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/mult_share_ctrl_arb.sv
// rr_arbiter2: two-requester round-robin grant.
//   Clk, Reset  clock / synchronous active-high reset
//   req_valid   request lines, bit i = requester i
//   accept      grant was taken this cycle; pointer moves only then
//   grant       one-hot grant (zero when nobody requests)
//   grant_id    index of the granted requester
module rr_arbiter2
    import mult_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic [1:0] req_valid,
    input  logic       accept,
    output logic [1:0] grant,
    output logic       grant_id
);

    // Last requester that was accepted. Resets to 1 so req0 wins the first tie.
    logic last_q;

    always_comb begin
        grant_id = 1'b0;
        case (req_valid)
            2'b01:   grant_id = 1'b0;
            2'b10:   grant_id = 1'b1;
            2'b11:   grant_id = ~last_q;
            default: grant_id = 1'b0;
        endcase
        grant = 2'b00;
        if (|req_valid)
            grant = grant_id ? 2'b10 : 2'b01;
    end

    always_ff @(posedge Clk) begin
        if (Reset)
            last_q <= 1'b1;
        else if (accept)
            last_q <= grant_id;
    end

endmodule

// File: rtl/mult_share_ctrl.sv
// mult_share_ctrl: one signed shift-add multiplier time-shared between two
// requesters. Each operation runs WIDTH add/shift pairs; the last add is a
// subtract, because the multiplier MSB carries negative weight.
//   Clk, Reset              clock / synchronous active-high reset
//   req_valid/req_ready     per-requester handshake (bit i = requester i)
//   req_mcand, req_mplier   operands, requester i in slice [i*WIDTH +: WIDTH]
//   resp_valid/resp_ready   product handshake
//   resp_id, resp_prod      owner and {A,B} product, held stable in DONE
//   busy                    sequencer not in IDLE
//   dbg_aval, dbg_bval      live A / B registers for the hex display
module mult_share_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [2*WIDTH-1:0]   req_mcand,
    input  logic [2*WIDTH-1:0]   req_mplier,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic                 resp_id,
    output logic [2*WIDTH-1:0]   resp_prod,
    output logic                 busy,
    output logic [WIDTH-1:0]     dbg_aval,
    output logic [WIDTH-1:0]     dbg_bval
);

    localparam int CW = cnt_bits(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, s_q;
    logic             x_q;
    logic [CW-1:0]    cnt_q;
    logic             id_q;

    logic [1:0]       gnt;
    logic             gnt_id;
    logic             accept;
    logic             cnt_last;
    logic [WIDTH-1:0] sel_mcand, sel_mplier;
    logic [WIDTH:0]   a_ext, s_ext, sum;

    // Any valid request produces a grant, so IDLE plus a valid means accept.
    // Reset blocks the handshake so nothing is taken in a cycle being wiped.
    assign accept   = (state_q == IDLE) && !Reset && (|req_valid);
    assign cnt_last = (cnt_q == CW'(WIDTH-1));

    assign sel_mcand  = gnt_id ? req_mcand[2*WIDTH-1:WIDTH]  : req_mcand[WIDTH-1:0];
    assign sel_mplier = gnt_id ? req_mplier[2*WIDTH-1:WIDTH] : req_mplier[WIDTH-1:0];

    rr_arbiter2 u_arb (
        .Clk       (Clk),
        .Reset     (Reset),
        .req_valid (req_valid),
        .accept    (accept),
        .grant     (gnt),
        .grant_id  (gnt_id)
    );

    // WIDTH+1 bit add/sub on sign-extended operands; bit WIDTH becomes X.
    always_comb begin
        a_ext = {a_q[WIDTH-1], a_q};
        s_ext = {s_q[WIDTH-1], s_q};
        sum   = cnt_last ? (a_ext - s_ext) : (a_ext + s_ext);
    end

    always_ff @(posedge Clk) begin
        if (Reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ADD;
            ADD:     state_d = SHIFT;
            SHIFT:   state_d = cnt_last ? DONE : ADD;
            DONE:    if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign req_ready  = (state_q == IDLE && !Reset) ? gnt : 2'b00;
    assign resp_valid = (state_q == DONE) && !Reset;
    assign resp_prod  = {a_q, b_q};
    assign resp_id    = id_q;
    assign busy       = (state_q != IDLE);
    assign dbg_aval   = a_q;
    assign dbg_bval   = b_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            a_q   <= '0;
            b_q   <= '0;
            s_q   <= '0;
            x_q   <= 1'b0;
            cnt_q <= '0;
            id_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        s_q   <= sel_mcand;
                        b_q   <= sel_mplier;
                        a_q   <= '0;
                        x_q   <= 1'b0;
                        cnt_q <= '0;
                        id_q  <= gnt_id;
                    end
                end
                ADD: begin
                    if (b_q[0])
                        {x_q, a_q} <= sum;
                end
                SHIFT: begin
                    // Arithmetic shift of {X,A,B}: X replicates into A's MSB.
                    {x_q, a_q, b_q} <= {x_q, x_q, a_q, b_q[WIDTH-1:1]};
                    if (!cnt_last)
                        cnt_q <= cnt_q + CW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
